// File: rtl/ofdm_tx_frame_sched_pkg.sv
// Shared definitions for the 802.22 TX frame scheduler.
// Holds the IQ sample layout, default symbol/preamble geometry, the
// scheduler state encoding and the beat-counter width helper.
package ofdm_tx_frame_sched_pkg;

    localparam int unsigned IQ_W         = 32;
    localparam int unsigned FFT_LEN      = 2048;
    localparam int unsigned CP_LEN       = 512;
    localparam int unsigned SYM_LEN_DFLT = FFT_LEN + CP_LEN;
    localparam int unsigned PRE_LEN_DFLT = 5120;
    localparam int unsigned NSYM_W_DFLT  = 8;

    // One complex sample as carried on every stream port.
    typedef struct packed {
        logic [15:0] i;
        logic [15:0] q;
    } iq_sample_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2
    } sched_state_e;

    // Bits needed to count beats of the longer of preamble and symbol.
    function automatic int unsigned beat_cnt_width(input int unsigned pre_len,
                                                   input int unsigned sym_len);
        int unsigned m;
        m = (pre_len > sym_len) ? pre_len : sym_len;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/ofdm_tx_frame_sched_frame_beat_counter.sv
// frame_beat_counter: beat and symbol position inside a TX frame.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clr           restart both counters at frame start
//   adv           one beat completed this cycle
//   pre_phase     1 while counting preamble beats, 0 for data symbols
//   nsym          symbols in the current frame (latched by the caller)
//   beat_last_c   current beat is the last of the preamble / symbol
//   sym_last_c    current symbol is the last of the frame
module frame_beat_counter
    import ofdm_tx_frame_sched_pkg::*;
#(
    parameter int unsigned PRE_LEN = PRE_LEN_DFLT,
    parameter int unsigned SYM_LEN = SYM_LEN_DFLT,
    parameter int unsigned NSYM_W  = NSYM_W_DFLT,
    parameter int unsigned BEAT_W  = beat_cnt_width(PRE_LEN, SYM_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    input  logic              pre_phase,
    input  logic [NSYM_W-1:0] nsym,
    output logic              beat_last_c,
    output logic              sym_last_c
);

    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [NSYM_W-1:0] sym_cnt_q,  sym_cnt_d;
    logic [BEAT_W-1:0] beat_term;

    // Terminal-count flags and next counter values.
    always_comb begin
        beat_term   = pre_phase ? BEAT_W'(PRE_LEN - 1) : BEAT_W'(SYM_LEN - 1);
        beat_last_c = (beat_cnt_q == beat_term);
        sym_last_c  = (sym_cnt_q == (nsym - NSYM_W'(1)));
        beat_cnt_d  = beat_cnt_q;
        sym_cnt_d   = sym_cnt_q;
        if (clr) begin
            beat_cnt_d = '0;
            sym_cnt_d  = '0;
        end else if (adv) begin
            if (beat_last_c) begin
                beat_cnt_d = '0;
                // Only data symbols are counted; the preamble wrap leaves sym_cnt at 0.
                if (!pre_phase) begin
                    sym_cnt_d = sym_cnt_q + NSYM_W'(1);
                end
            end else begin
                beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_q <= '0;
            sym_cnt_q  <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            sym_cnt_q  <= sym_cnt_d;
        end
    end

endmodule

// File: rtl/ofdm_tx_frame_sched.sv
// ofdm_tx_frame_sched: frame scheduler between IFFT_Mod and Tx_Out.
// Forwards PRE_LEN preamble beats then NSYM*SYM_LEN data beats per frame,
// framed by CYC_O, through a zero-latency source mux.
// Ports:
//   CLK_I, RST_I          clock, asynchronous active-high reset
//   NSYM_I                data symbols per frame, latched at frame start
//   P_DAT_I/P_STB_I/P_ACK_O   preamble source handshake
//   D_DAT_I/D_CYC_I/D_STB_I/D_ACK_O   IFFT data source handshake
//   DAT_O/CYC_O/STB_O/WE_O/ACK_I      output stream to Tx_Out
//   FRM_DONE_O            one-cycle pulse after the last beat of a frame
//   UNDERRUN_O            one-cycle pulse when the data source aborts a frame
module ofdm_tx_frame_sched
    import ofdm_tx_frame_sched_pkg::*;
#(
    parameter int unsigned SYM_LEN = SYM_LEN_DFLT,
    parameter int unsigned PRE_LEN = PRE_LEN_DFLT,
    parameter int unsigned NSYM_W  = NSYM_W_DFLT
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic [NSYM_W-1:0] NSYM_I,
    input  logic [IQ_W-1:0]   P_DAT_I,
    input  logic              P_STB_I,
    output logic              P_ACK_O,
    input  logic [IQ_W-1:0]   D_DAT_I,
    input  logic              D_CYC_I,
    input  logic              D_STB_I,
    output logic              D_ACK_O,
    output logic [IQ_W-1:0]   DAT_O,
    output logic              CYC_O,
    output logic              STB_O,
    output logic              WE_O,
    input  logic              ACK_I,
    output logic              FRM_DONE_O,
    output logic              UNDERRUN_O
);

    localparam int unsigned BEAT_W = beat_cnt_width(PRE_LEN, SYM_LEN);

    sched_state_e      state_q,    state_d;
    logic [NSYM_W-1:0] nsym_q,     nsym_d;
    logic              cyc_q,      cyc_d;
    logic              frm_done_q, frm_done_d;
    logic              underrun_q, underrun_d;

    iq_sample_t        dat_c;
    logic              stb_c;
    logic              p_ack_c;
    logic              d_ack_c;
    logic              cnt_clr;
    logic              cnt_adv;
    logic              beat_last_c;
    logic              sym_last_c;

    frame_beat_counter #(
        .PRE_LEN (PRE_LEN),
        .SYM_LEN (SYM_LEN),
        .NSYM_W  (NSYM_W),
        .BEAT_W  (BEAT_W)
    ) u_cnt (
        .clk         (CLK_I),
        .rst         (RST_I),
        .clr         (cnt_clr),
        .adv         (cnt_adv),
        .pre_phase   (state_q == ST_PRE),
        .nsym        (nsym_q),
        .beat_last_c (beat_last_c),
        .sym_last_c  (sym_last_c)
    );

    // Source mux and frame sequencing.
    always_comb begin
        state_d    = state_q;
        nsym_d     = nsym_q;
        cyc_d      = cyc_q;
        frm_done_d = 1'b0;
        underrun_d = 1'b0;
        cnt_clr    = 1'b0;
        cnt_adv    = 1'b0;
        dat_c      = '0;
        stb_c      = 1'b0;
        p_ack_c    = 1'b0;
        d_ack_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (D_CYC_I) begin
                    state_d = ST_PRE;
                    nsym_d  = NSYM_I;
                    cnt_clr = 1'b1;
                    cyc_d   = 1'b1;
                end
            end

            ST_PRE: begin
                // Data-source abort is ignored here: the preamble always completes.
                dat_c   = P_DAT_I;
                stb_c   = P_STB_I;
                p_ack_c = ACK_I & P_STB_I;
                cnt_adv = p_ack_c;
                if (p_ack_c && beat_last_c) begin
                    if (nsym_q == '0) begin
                        state_d    = ST_IDLE;
                        cyc_d      = 1'b0;
                        frm_done_d = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                dat_c   = D_DAT_I;
                stb_c   = D_STB_I;
                d_ack_c = ACK_I & D_STB_I;
                cnt_adv = d_ack_c;
                // The final beat wins over a simultaneous D_CYC_I drop.
                if (d_ack_c && beat_last_c && sym_last_c) begin
                    state_d    = ST_IDLE;
                    cyc_d      = 1'b0;
                    frm_done_d = 1'b1;
                end else if (!D_CYC_I) begin
                    state_d    = ST_IDLE;
                    cyc_d      = 1'b0;
                    underrun_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    // Scheduler state and registered status.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q    <= ST_IDLE;
            nsym_q     <= '0;
            cyc_q      <= 1'b0;
            frm_done_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            nsym_q     <= nsym_d;
            cyc_q      <= cyc_d;
            frm_done_q <= frm_done_d;
            underrun_q <= underrun_d;
        end
    end

    assign DAT_O      = dat_c;
    assign STB_O      = stb_c;
    assign WE_O       = stb_c;
    assign P_ACK_O    = p_ack_c;
    assign D_ACK_O    = d_ack_c;
    assign CYC_O      = cyc_q;
    assign FRM_DONE_O = frm_done_q;
    assign UNDERRUN_O = underrun_q;

endmodule

// File: tb/tb_ofdm_tx_frame_sched.sv
// Scoreboard bench for ofdm_tx_frame_sched with a small frame geometry.
// Sources are word streams that advance on their ACK; the model predicts,
// per frame, which stream words must appear on DAT_O and how the frame ends.
module tb_ofdm_tx_frame_sched;

    localparam int unsigned SYM_LEN = 4;
    localparam int unsigned PRE_LEN = 3;
    localparam int unsigned NSYM_W  = 8;

    localparam int K_PRE  = 0;
    localparam int K_DAT  = 1;
    localparam int K_DONE = 2;
    localparam int K_UND  = 3;
    localparam int K_NONE = 7;

    typedef struct {
        int          kind;
        logic [31:0] dat;
    } exp_t;

    logic              CLK_I = 1'b0;
    logic              RST_I = 1'b1;
    logic [NSYM_W-1:0] NSYM_I = '0;
    logic [31:0]       P_DAT_I;
    logic              P_STB_I = 1'b1;
    logic              P_ACK_O;
    logic [31:0]       D_DAT_I;
    logic              D_CYC_I = 1'b0;
    logic              D_STB_I = 1'b1;
    logic              D_ACK_O;
    logic [31:0]       DAT_O;
    logic              CYC_O;
    logic              STB_O;
    logic              WE_O;
    logic              ACK_I = 1'b1;
    logic              FRM_DONE_O;
    logic              UNDERRUN_O;

    logic [31:0] pre_mem [1024];
    logic [31:0] dat_mem [1024];
    int p_idx = 0;
    int d_idx = 0;

    exp_t exp_q[$];
    int   exp_run[$];
    int   exp_gap[$];

    int n_vec = 0;
    int n_err = 0;
    int to_cnt = 0;
    int m_pre = 0;
    int m_dat = 0;
    int ack_mode = 0;
    bit stb_rand = 1'b0;
    bit end_req = 1'b0;
    bit end_done = 1'b0;

    always #5 CLK_I = ~CLK_I;

    ofdm_tx_frame_sched #(
        .SYM_LEN (SYM_LEN),
        .PRE_LEN (PRE_LEN),
        .NSYM_W  (NSYM_W)
    ) dut (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .NSYM_I     (NSYM_I),
        .P_DAT_I    (P_DAT_I),
        .P_STB_I    (P_STB_I),
        .P_ACK_O    (P_ACK_O),
        .D_DAT_I    (D_DAT_I),
        .D_CYC_I    (D_CYC_I),
        .D_STB_I    (D_STB_I),
        .D_ACK_O    (D_ACK_O),
        .DAT_O      (DAT_O),
        .CYC_O      (CYC_O),
        .STB_O      (STB_O),
        .WE_O       (WE_O),
        .ACK_I      (ACK_I),
        .FRM_DONE_O (FRM_DONE_O),
        .UNDERRUN_O (UNDERRUN_O)
    );

    // Upstream sources: each presents its next stream word until accepted.
    assign P_DAT_I = pre_mem[p_idx[9:0]];
    assign D_DAT_I = dat_mem[d_idx[9:0]];

    always @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            p_idx <= 0;
            d_idx <= 0;
        end else begin
            if (P_ACK_O) p_idx <= p_idx + 1;
            if (D_ACK_O) d_idx <= d_idx + 1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int  mon_cyc = 0;
    int  last_beat_cyc = -100;
    int  hi_run = 0;
    int  lo_run = 0;
    bit  prev_cyc = 1'b0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge CLK_I) begin
        int   gk;
        int   ek;
        exp_t e;
        mon_cyc++;
        if (RST_I) begin
            chk("reset_outputs_zero",
                64'({DAT_O, STB_O, WE_O, CYC_O, P_ACK_O, D_ACK_O, FRM_DONE_O, UNDERRUN_O}), 64'd0);
            exp_q.delete();
            exp_run.delete();
            exp_gap.delete();
            prev_cyc = 1'b0;
            hi_run   = 0;
            lo_run   = 0;
        end else begin
            chk("we_equals_stb", 64'(WE_O), 64'(STB_O));
            chk("src_ack_vs_out_beat", 64'(P_ACK_O | D_ACK_O), 64'(STB_O & ACK_I));
            if (!ACK_I) chk("src_ack_while_stalled", 64'({P_ACK_O, D_ACK_O}), 64'd0);

            if (STB_O && ACK_I) begin
                gk = P_ACK_O ? K_PRE : (D_ACK_O ? K_DAT : 5);
                ek = (exp_q.size() == 0) ? K_NONE : exp_q[0].kind;
                chk("beat_source", 64'(gk), 64'(ek));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    if (e.kind <= K_DAT) chk("beat_data", 64'(DAT_O), 64'(e.dat));
                end
                chk("cyc_during_beat", 64'(CYC_O), 64'd1);
                last_beat_cyc = mon_cyc;
            end

            if (FRM_DONE_O || UNDERRUN_O) begin
                gk = FRM_DONE_O ? (UNDERRUN_O ? 6 : K_DONE) : K_UND;
                ek = (exp_q.size() == 0) ? K_NONE : exp_q[0].kind;
                chk("frame_end_kind", 64'(gk), 64'(ek));
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                if (FRM_DONE_O) chk("done_after_last_beat", 64'(mon_cyc - last_beat_cyc), 64'd1);
                chk("cyc_low_at_frame_end", 64'(CYC_O), 64'd0);
            end

            if (CYC_O) begin
                if (!prev_cyc) begin
                    chk("frame_start_expected", 64'(exp_gap.size() > 0), 64'd1);
                    if (exp_gap.size() != 0) begin
                        int g;
                        g = exp_gap.pop_front();
                        if (g >= 0) chk("cyc_low_gap", 64'(lo_run), 64'(g));
                    end
                    hi_run = 1;
                end else begin
                    hi_run++;
                end
            end else begin
                if (prev_cyc) begin
                    if (exp_run.size() != 0) begin
                        int r;
                        r = exp_run.pop_front();
                        if (r >= 0) chk("cyc_high_len", 64'(hi_run), 64'(r));
                    end
                    lo_run = 1;
                end else begin
                    lo_run++;
                end
            end
            prev_cyc = CYC_O;
        end

        if (end_req && !end_done) begin
            chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
            chk("no_wait_timeouts", 64'(to_cnt), 64'd0);
            end_done = 1'b1;
        end
    end

    // ---------------- reference model & stimulus ----------------
    // Expected frame: next PRE_LEN preamble words, next n_dat data words, then the end event.
    task automatic push_frame(input int n_dat, input int evt, input int run, input int gap);
        for (int k = 0; k < int'(PRE_LEN); k++) begin
            exp_q.push_back('{K_PRE, pre_mem[m_pre % 1024]});
            m_pre++;
        end
        for (int k = 0; k < n_dat; k++) begin
            exp_q.push_back('{K_DAT, dat_mem[m_dat % 1024]});
            m_dat++;
        end
        exp_q.push_back('{evt, 32'd0});
        exp_run.push_back(run);
        exp_gap.push_back(gap);
    endtask

    task automatic step();
        @(posedge CLK_I);
        #1;
        case (ack_mode)
            0:       ACK_I = 1'b1;
            1:       ACK_I = ~ACK_I;
            default: ACK_I = ($urandom_range(0, 3) != 0);
        endcase
        if (stb_rand) begin
            P_STB_I = ($urandom_range(0, 3) != 0);
            D_STB_I = ($urandom_range(0, 3) != 0);
        end else begin
            P_STB_I = 1'b1;
            D_STB_I = 1'b1;
        end
    endtask

    task automatic start_frame(input int n, input int run, input int gap);
        NSYM_I  = NSYM_W'(n);
        D_CYC_I = 1'b1;
        push_frame(n * int'(SYM_LEN), K_DONE, run, gap);
    endtask

    task automatic wait_evt(input bit drop, input bit mutate);
        int b;
        b = 0;
        forever begin
            step();
            if (FRM_DONE_O || UNDERRUN_O) break;
            b++;
            if (b > 500) begin
                to_cnt++;
                $display("FAIL wait_frame_end: got no frame end within 500 cycles, expected one");
                break;
            end
            if (mutate && $urandom_range(0, 7) == 0) NSYM_I = NSYM_W'($urandom_range(0, 3));
        end
        if (drop) D_CYC_I = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int base;
        int b;
        for (int i = 0; i < 1024; i++) begin
            pre_mem[i] = $urandom;
            dat_mem[i] = $urandom;
        end
        idle(3);
        RST_I = 1'b0;
        idle(2);

        // Nominal frame, no stalls: 3 + 8 beats, CYC_O high 11 cycles.
        ack_mode = 0; stb_rand = 1'b0;
        start_frame(2, int'(PRE_LEN + 2 * SYM_LEN), -1);
        wait_evt(1'b1, 1'b0);
        idle(2);

        // Alternating ACK_I stalls.
        ack_mode = 1;
        start_frame(2, -1, -1);
        wait_evt(1'b1, 1'b0);
        idle(2);

        // Preamble-only frame.
        ack_mode = 0;
        start_frame(0, int'(PRE_LEN), -1);
        wait_evt(1'b1, 1'b0);
        idle(2);

        // Data source aborts after 5 data beats, then a fresh frame.
        base = d_idx;
        NSYM_I  = NSYM_W'(2);
        D_CYC_I = 1'b1;
        push_frame(5, K_UND, int'(PRE_LEN) + 5 + 1, -1);
        b = 0;
        while ((d_idx - base) < 5 && b < 200) begin
            step();
            b++;
        end
        if (b >= 200) begin
            to_cnt++;
            $display("FAIL wait_data_beats: got %0d data beats, expected 5", d_idx - base);
        end
        D_CYC_I = 1'b0;
        D_STB_I = 1'b0;
        wait_evt(1'b1, 1'b0);
        idle(1);
        start_frame(1, int'(PRE_LEN + SYM_LEN), -1);
        wait_evt(1'b1, 1'b0);
        idle(2);

        // Back-to-back frames, NSYM_I 2 -> 1 during frame 1.
        start_frame(2, int'(PRE_LEN + 2 * SYM_LEN), -1);
        idle(4);
        NSYM_I = NSYM_W'(1);
        push_frame(int'(SYM_LEN), K_DONE, int'(PRE_LEN + SYM_LEN), 1);
        wait_evt(1'b0, 1'b0);
        wait_evt(1'b1, 1'b0);
        idle(2);

        // Asynchronous reset in the middle of the data phase.
        base = d_idx;
        start_frame(2, -1, -1);
        b = 0;
        while ((d_idx - base) < 2 && b < 200) begin
            step();
            b++;
        end
        #2;
        RST_I   = 1'b1;
        D_CYC_I = 1'b0;
        m_pre   = 0;
        m_dat   = 0;
        idle(2);
        RST_I = 1'b0;
        idle(1);
        start_frame(1, int'(PRE_LEN + SYM_LEN), -1);
        wait_evt(1'b1, 1'b0);

        // Randomized frames with random stalls and mid-frame NSYM_I changes.
        ack_mode = 2; stb_rand = 1'b1;
        for (int f = 0; f < 30; f++) begin
            start_frame(int'($urandom_range(0, 3)), -1, -1);
            wait_evt(1'b1, 1'b1);
            idle(int'($urandom_range(0, 2)));
        end

        D_CYC_I = 1'b0;
        idle(3);
        end_req = 1'b1;
        b = 0;
        while (!end_done && b < 10) begin
            step();
            b++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ofdm_tx_frame_sched.md
Name: ofdm_tx_frame_sched

Overview:
- Frame scheduler between IFFT_Mod and Tx_Out in the 802.22 TX chain.
- Arbitrates two 32-bit IQ sample streams into one output stream: a preamble source and the IFFT data-symbol source.
- Per frame it forwards exactly PRE_LEN preamble beats, then NSYM*SYM_LEN data beats, framed by CYC_O.
- Provides frame-done and underrun status to the MAC/control layer.

Parameters:
- SYM_LEN, 2560: samples per OFDM symbol, including CP (2048 FFT + 1/4 CP).
- PRE_LEN, 5120: preamble samples per frame.
- NSYM_W, 8: width of the symbols-per-frame configuration.

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  reset, asynchronous, active-high.
- NSYM_I  in  NSYM_W  data symbols per frame; sampled at frame start.
- P_DAT_I  in  32  preamble sample, {I[15:0],Q[15:0]}.
- P_STB_I  in  1  preamble sample valid.
- P_ACK_O  out  1  preamble beat accepted.
- D_DAT_I  in  32  IFFT output sample.
- D_CYC_I  in  1  data source has a frame pending/in progress.
- D_STB_I  in  1  data sample valid.
- D_ACK_O  out  1  data beat accepted.
- DAT_O  out  32  output sample to Tx_Out.
- CYC_O  out  1  frame in progress.
- STB_O  out  1  output sample valid.
- WE_O  out  1  equals STB_O.
- ACK_I  in  1  Tx_Out accepts beat.
- FRM_DONE_O  out  1  one-cycle pulse after the last beat of a frame.
- UNDERRUN_O  out  1  one-cycle pulse on frame abort.

Behaviour:
- A beat completes on any port in a cycle where its STB and ACK are both high.
- Reset (async assert, sync release to CLK_I):
  - state=IDLE, counters=0, nsym_q=0.
  - CYC_O, STB_O, P_ACK_O, D_ACK_O, FRM_DONE_O, UNDERRUN_O = 0.
  - DAT_O = 0.
- Mux is combinational, so there is zero latency from source to output:
  - PRE: DAT_O=P_DAT_I, STB_O=P_STB_I, P_ACK_O=ACK_I&P_STB_I, D_ACK_O=0.
  - DATA: DAT_O=D_DAT_I, STB_O=D_STB_I, D_ACK_O=ACK_I&D_STB_I, P_ACK_O=0.
  - IDLE: DAT_O=0, STB_O=0, both source ACKs = 0.
- FSM states IDLE, PRE, DATA:
  - IDLE -> PRE when D_CYC_I=1. Same edge: nsym_q<=NSYM_I, beat_cnt<=0, sym_cnt<=0. CYC_O is registered and goes high in the first PRE cycle.
  - PRE: beat_cnt increments per completed beat. On the beat with beat_cnt=PRE_LEN-1: beat_cnt<=0; go to DATA, or go to IDLE with FRM_DONE_O if nsym_q=0.
  - DATA: beat_cnt increments per beat and wraps at SYM_LEN-1. On each wrap sym_cnt increments. On the beat with beat_cnt=SYM_LEN-1 and sym_cnt=nsym_q-1: go to IDLE, FRM_DONE_O=1 next cycle, CYC_O=0 next cycle.
  - DATA with D_CYC_I=0 before the last beat (underrun/abort): go to IDLE next edge, UNDERRUN_O pulses, CYC_O drops. A beat completing in the same cycle still passes through. Preamble-phase drop of D_CYC_I is ignored; the preamble always completes.
- Back-to-back frames: from IDLE, with D_CYC_I still high, the next frame starts one cycle after FRM_DONE. CYC_O has a minimum one-cycle low gap.
- NSYM_I changes mid-frame have no effect until the next IDLE->PRE transition.
- Stalls: ACK_I=0 or STB low holds the counters. There is no timeout.
- Counter widths: beat_cnt is clog2(max(PRE_LEN,SYM_LEN)); sym_cnt is NSYM_W.
- Reset mid-frame: immediate return to IDLE with outputs low. The partial frame is discarded and there is no UNDERRUN pulse.

Decomposition:
- Shared package:
  - State encoding (IDLE/PRE/DATA).
  - IQ sample width constant (32).
  - Default 802.22 constants: FFT 2048, CP 512, SYM_LEN, PRE_LEN.
- Sub-module frame_beat_counter: holds beat_cnt/sym_cnt with wrap and terminal-count flags. The top holds the FSM and mux.

Test Plan:
- SYM_LEN=4, PRE_LEN=3, NSYM_I=2, both sources always valid, ACK_I=1 -> CYC_O high for exactly 11 cycles. DAT_O shows 3 preamble then 8 data samples in order. FRM_DONE_O pulses once, in the cycle after the 11th beat.
- Same setup with ACK_I toggling 1,0,1,0 -> 11 beats total, no sample duplicated or dropped, counters frozen on ACK_I=0 cycles, P_ACK_O/D_ACK_O never high while ACK_I=0.
- NSYM_I=0 -> exactly 3 preamble beats, D_ACK_O never asserted, FRM_DONE_O pulses, state returns to IDLE.
- D_CYC_I dropped after 5 data beats (NSYM_I=2) -> UNDERRUN_O pulses once, CYC_O low next cycle, no FRM_DONE_O. A fresh D_CYC_I then restarts with preamble beat 0.
- D_CYC_I held high for two frames, NSYM_I changed 2->1 during frame 1 -> frame 1 has 8 data beats, frame 2 has 4, with exactly one CYC_O-low cycle between them.
- RST_I asserted asynchronously mid-DATA -> all outputs 0 in the same cycle, without waiting for a clock edge. After release, IDLE; a new frame starts cleanly from the preamble.
